// File: rtl/elevator_car_controller_pkg.sv
// Shared definitions for the elevator car controller: direction codes, sizes,
// hall-button bit indexing and the controller state encoding.
package elevator_pkg;

  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned NUM_FLOORS = 7;
  localparam int unsigned BTN_W      = 14;

  localparam logic [1:0] STOP   = 2'b00;
  localparam logic [1:0] UP     = 2'b10;
  localparam logic [1:0] DOWN   = 2'b01;
  localparam logic [1:0] UPDOWN = 2'b11;

  // Floor 1 has no DOWN call and floor 7 has no UP call.
  localparam logic [BTN_W-1:0] HALL_MASK = 14'h1FFE;

  typedef enum logic [1:0] {StIdle, StMove, StCheck, StDoor} state_e;

  // Floor f (1-based) owns hall bits {UP, DOWN} at [2f-1 : 2f-2].
  function automatic logic [3:0] btn_idx(input logic [FLOOR_W-1:0] floor, input logic is_up);
    btn_idx = {floor, 1'b0} - 4'd2 + {3'b000, is_up};
  endfunction

endpackage

// File: rtl/elevator_car_controller_if.sv
// Button/status bundle between one elevator car controller and its assigner.
interface elevator_car_controller_if;
  import elevator_pkg::*;

  logic [BTN_W-1:0]      floorButton;
  logic [NUM_FLOORS-1:0] carButton;
  logic                  doorHoldButton;
  logic [FLOOR_W-1:0]    currentFloor;
  logic [1:0]            direction;
  logic                  doorOpen;
  logic [BTN_W-1:0]      servedButton;
  logic [NUM_FLOORS-1:0] carCallPending;

  modport master (
    output floorButton, carButton, doorHoldButton,
    input  currentFloor, direction, doorOpen, servedButton, carCallPending
  );

  modport slave (
    input  floorButton, carButton, doorHoldButton,
    output currentFloor, direction, doorOpen, servedButton, carCallPending
  );

endinterface

// File: rtl/elevator_car_controller_request_scan.sv
// Combinational request summary relative to the car's current floor.
module elevator_request_scan
  import elevator_pkg::*;
(
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  input  logic [BTN_W-1:0]      floor_button_i,
  input  logic [NUM_FLOORS-1:0] car_call_i,
  output logic                  req_above_o,
  output logic                  req_below_o,
  output logic                  req_here_up_o,
  output logic                  req_here_down_o,
  output logic                  car_here_o
);

  logic [BTN_W-1:0] hall;

  assign hall = floor_button_i & HALL_MASK;

  always_comb begin
    req_above_o = 1'b0;
    req_below_o = 1'b0;
    for (int f = 1; f <= int'(NUM_FLOORS); f++) begin
      if (f > int'(cur_floor_i)) begin
        req_above_o = req_above_o | hall[2*f-1] | hall[2*f-2] | car_call_i[f-1];
      end
      if (f < int'(cur_floor_i)) begin
        req_below_o = req_below_o | hall[2*f-1] | hall[2*f-2] | car_call_i[f-1];
      end
    end
  end

  assign req_here_up_o   = hall[btn_idx(cur_floor_i, 1'b1)];
  assign req_here_down_o = hall[btn_idx(cur_floor_i, 1'b0)];
  assign car_here_o      = car_call_i[cur_floor_i - FLOOR_W'(1)];

endmodule

// File: rtl/elevator_car_controller.sv
// Per-car SCAN motion and door sequencer: serves assigned hall calls and
// latched cabin calls, reporting each served hall bit with a one-cycle pulse.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_TICKS = 16,
  parameter int unsigned DOOR_TICKS  = 32
) (
  input logic                      clk,
  input logic                      reset,
  elevator_car_controller_if.slave bus
);

  localparam int unsigned MoveCntW = $clog2(FLOOR_TICKS);
  localparam int unsigned DoorCntW = $clog2(DOOR_TICKS);
  localparam logic [MoveCntW-1:0] MoveLast = MoveCntW'(FLOOR_TICKS - 1);
  localparam logic [DoorCntW-1:0] DoorLast = DoorCntW'(DOOR_TICKS - 1);

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [1:0]            dir_q, dir_d;
  logic [BTN_W-1:0]      served_q, served_d;
  logic [NUM_FLOORS-1:0] car_call_q, car_call_d;
  logic [MoveCntW-1:0]   move_cnt_q, move_cnt_d;
  logic [DoorCntW-1:0]   door_cnt_q, door_cnt_d;

  logic                  door_open;
  logic [NUM_FLOORS-1:0] car_oh, calls_live;
  logic [BTN_W-1:0]      up_oh, dn_oh, dir_oh, opp_oh, new_bits;
  logic                  req_above, req_below, here_up, here_dn, car_here;
  logic                  going_up, ahead, behind, here_dir, here_opp;
  logic [1:0]            flip_dir;

  assign door_open = (state_q == StDoor);
  assign car_oh    = NUM_FLOORS'(1) << (floor_q - FLOOR_W'(1));
  // A cabin press for the open-door floor is dropped rather than latched.
  assign calls_live = car_call_q | (bus.carButton & ~(door_open ? car_oh : '0));

  elevator_request_scan u_scan (
    .cur_floor_i     (floor_q),
    .floor_button_i  (bus.floorButton),
    .car_call_i      (calls_live),
    .req_above_o     (req_above),
    .req_below_o     (req_below),
    .req_here_up_o   (here_up),
    .req_here_down_o (here_dn),
    .car_here_o      (car_here)
  );

  assign up_oh    = BTN_W'(1) << btn_idx(floor_q, 1'b1);
  assign dn_oh    = BTN_W'(1) << btn_idx(floor_q, 1'b0);
  assign going_up = (dir_q == UP);
  assign ahead    = going_up ? req_above : req_below;
  assign behind   = going_up ? req_below : req_above;
  assign here_dir = going_up ? here_up : here_dn;
  assign here_opp = going_up ? here_dn : here_up;
  assign dir_oh   = going_up ? up_oh : dn_oh;
  assign opp_oh   = going_up ? dn_oh : up_oh;
  assign flip_dir = going_up ? DOWN : UP;

  // Calls already pulsed this cycle are still visible until the assigner drops them.
  always_comb begin
    if (dir_q == STOP) begin
      new_bits = ({BTN_W{here_up}} & up_oh) | ({BTN_W{here_dn}} & dn_oh);
    end else begin
      new_bits = {BTN_W{here_dir}} & dir_oh;
    end
    new_bits = new_bits & ~served_q;
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    served_d   = '0;
    car_call_d = calls_live;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (car_here || here_up || here_dn) begin
          state_d    = StDoor;
          door_cnt_d = '0;
          served_d   = ({BTN_W{here_up}} & up_oh) | ({BTN_W{here_dn}} & dn_oh);
          car_call_d = calls_live & ~car_oh;
        end else if (req_above) begin
          state_d    = StMove;
          dir_d      = UP;
          move_cnt_d = '0;
        end else if (req_below) begin
          state_d    = StMove;
          dir_d      = DOWN;
          move_cnt_d = '0;
        end
      end

      StMove: begin
        if (move_cnt_q == MoveLast) begin
          state_d    = StCheck;
          move_cnt_d = '0;
          floor_d    = going_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        end else begin
          move_cnt_d = move_cnt_q + MoveCntW'(1);
        end
      end

      StCheck: begin
        if (car_here || here_dir || (here_opp && !ahead)) begin
          state_d    = StDoor;
          door_cnt_d = '0;
          car_call_d = calls_live & ~car_oh;
          if (here_dir) begin
            served_d = dir_oh;
          end else if (here_opp && !ahead) begin
            served_d = opp_oh;
            dir_d    = flip_dir;
          end
        end else if (ahead) begin
          state_d    = StMove;
          move_cnt_d = '0;
        end else if (behind) begin
          // Calls ahead were withdrawn; this also keeps the car inside 1..7.
          state_d    = StMove;
          dir_d      = flip_dir;
          move_cnt_d = '0;
        end else begin
          state_d = StIdle;
          dir_d   = STOP;
        end
      end

      StDoor: begin
        car_call_d = calls_live & ~car_oh;
        if (bus.doorHoldButton || (new_bits != '0)) begin
          door_cnt_d = '0;
          served_d   = new_bits;
        end else if (door_cnt_q == DoorLast) begin
          door_cnt_d = '0;
          if (dir_q == STOP) begin
            if (req_above) begin
              state_d    = StMove;
              dir_d      = UP;
              move_cnt_d = '0;
            end else if (req_below) begin
              state_d    = StMove;
              dir_d      = DOWN;
              move_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else if (ahead) begin
            state_d    = StMove;
            move_cnt_d = '0;
          end else if (here_opp) begin
            dir_d    = flip_dir;
            served_d = opp_oh;
          end else if (behind) begin
            state_d    = StMove;
            dir_d      = flip_dir;
            move_cnt_d = '0;
          end else begin
            state_d = StIdle;
            dir_d   = STOP;
          end
        end else begin
          door_cnt_d = door_cnt_q + DoorCntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      floor_q    <= FLOOR_W'(1);
      dir_q      <= STOP;
      served_q   <= '0;
      car_call_q <= '0;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
      served_q   <= served_d;
      car_call_q <= car_call_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
    end
  end

  assign bus.currentFloor   = floor_q;
  assign bus.direction      = dir_q;
  assign bus.doorOpen       = door_open;
  assign bus.servedButton   = served_q;
  assign bus.carCallPending = car_call_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller with FLOOR_TICKS = DOOR_TICKS = 4.
module tb_elevator_car_controller;
  import elevator_pkg::*;

  localparam int unsigned FT = 4;
  localparam int unsigned DT = 4;

  typedef struct {
    logic [6:0] car;
    logic [2:0] floor;
    logic [1:0] dir;
    logic       door;
    logic [6:0] pend;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  elevator_car_controller_if bus ();

  elevator_car_controller #(
    .FLOOR_TICKS (FT),
    .DOOR_TICKS  (DT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock; the bench acts as the assigner and drops any hall bit just served.
  task automatic cycle();
    @(posedge clk);
    #1;
    bus.floorButton = bus.floorButton & ~bus.servedButton;
  endtask

  task automatic wait_door(input logic val, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus.doorOpen === val) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic wait_floor(input logic [2:0] f, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus.currentFloor === f) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic wait_served(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (bus.servedButton !== '0) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  initial begin
    vec_t             vt[16];
    bit               ok;
    logic [BTN_W-1:0] seen_served;
    logic             seen_door;
    int               reentries;

    vt[0]  = '{7'h04, 3'd1, 2'b00, 1'b0, 7'h00};
    vt[1]  = '{7'h00, 3'd1, 2'b10, 1'b0, 7'h04};
    vt[2]  = '{7'h00, 3'd1, 2'b10, 1'b0, 7'h04};
    vt[3]  = '{7'h00, 3'd1, 2'b10, 1'b0, 7'h04};
    vt[4]  = '{7'h00, 3'd1, 2'b10, 1'b0, 7'h04};
    vt[5]  = '{7'h00, 3'd2, 2'b10, 1'b0, 7'h04};
    vt[6]  = '{7'h00, 3'd2, 2'b10, 1'b0, 7'h04};
    vt[7]  = '{7'h00, 3'd2, 2'b10, 1'b0, 7'h04};
    vt[8]  = '{7'h00, 3'd2, 2'b10, 1'b0, 7'h04};
    vt[9]  = '{7'h00, 3'd2, 2'b10, 1'b0, 7'h04};
    vt[10] = '{7'h00, 3'd3, 2'b10, 1'b0, 7'h04};
    vt[11] = '{7'h00, 3'd3, 2'b10, 1'b1, 7'h00};
    vt[12] = '{7'h00, 3'd3, 2'b10, 1'b1, 7'h00};
    vt[13] = '{7'h00, 3'd3, 2'b10, 1'b1, 7'h00};
    vt[14] = '{7'h00, 3'd3, 2'b10, 1'b1, 7'h00};
    vt[15] = '{7'h00, 3'd3, 2'b00, 1'b0, 7'h00};

    reset              = 1'b1;
    bus.floorButton    = '0;
    bus.carButton      = '0;
    bus.doorHoldButton = 1'b0;
    #12;
    check("reset floor", 32'(bus.currentFloor), 32'd1);
    check("reset dir", 32'(bus.direction), 32'd0);
    check("reset door", 32'(bus.doorOpen), 32'd0);
    check("reset served", 32'(bus.servedButton), 32'd0);
    check("reset pend", 32'(bus.carCallPending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();

    // Floor-7 UP and floor-1 DOWN do not exist and must be ignored.
    bus.floorButton = 14'h2001;
    seen_served = '0;
    seen_door   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      seen_served = seen_served | bus.servedButton;
      seen_door   = seen_door | bus.doorOpen;
    end
    check("masked floor", 32'(bus.currentFloor), 32'd1);
    check("masked dir", 32'(bus.direction), 32'd0);
    check("masked served", 32'(seen_served), 32'd0);
    check("masked door", 32'(seen_door), 32'd0);
    bus.floorButton = '0;
    cycle();

    // Cabin call to floor 3 from idle at floor 1, cycle by cycle.
    for (int i = 0; i < 16; i++) begin
      bus.carButton = vt[i].car;
      check($sformatf("v%0d floor", i), 32'(bus.currentFloor), 32'(vt[i].floor));
      check($sformatf("v%0d dir", i), 32'(bus.direction), 32'(vt[i].dir));
      check($sformatf("v%0d door", i), 32'(bus.doorOpen), 32'(vt[i].door));
      check($sformatf("v%0d pend", i), 32'(bus.carCallPending), 32'(vt[i].pend));
      check($sformatf("v%0d served", i), 32'(bus.servedButton), 32'd0);
      cycle();
    end

    // Door hold at floor 2.
    bus.carButton = 7'h02;
    cycle();
    bus.carButton = '0;
    wait_door(1'b1, ok);
    check("hold door reached", 32'(ok), 32'd1);
    check("hold floor", 32'(bus.currentFloor), 32'd2);
    bus.doorHoldButton = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold held %0d", k), 32'(bus.doorOpen), 32'd1);
      cycle();
    end
    bus.doorHoldButton = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold released %0d", k), 32'(bus.doorOpen), 32'd1);
      cycle();
    end
    check("hold closed", 32'(bus.doorOpen), 32'd0);
    check("hold idle dir", 32'(bus.direction), 32'd0);

    // Asynchronous reset while moving up out of floor 4.
    bus.carButton = 7'h40;
    cycle();
    bus.carButton = '0;
    wait_floor(3'd4, ok);
    check("rst floor4 reached", 32'(ok), 32'd1);
    cycle();
    check("rst pre floor", 32'(bus.currentFloor), 32'd4);
    check("rst pre dir", 32'(bus.direction), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("rst floor", 32'(bus.currentFloor), 32'd1);
    check("rst dir", 32'(bus.direction), 32'd0);
    check("rst door", 32'(bus.doorOpen), 32'd0);
    check("rst served", 32'(bus.servedButton), 32'd0);
    check("rst pend", 32'(bus.carCallPending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();

    // SCAN: pass floor-3 DOWN going up, serve floor-5 UP, return for floor-3 DOWN.
    bus.floorButton = 14'h0210;
    wait_served(ok);
    check("scan first serve", 32'(ok), 32'd1);
    check("scan served up5", 32'(bus.servedButton), 32'h0200);
    check("scan floor5", 32'(bus.currentFloor), 32'd5);
    check("scan door5", 32'(bus.doorOpen), 32'd1);
    check("scan dir5", 32'(bus.direction), 32'h2);
    cycle();
    wait_served(ok);
    check("scan second serve", 32'(ok), 32'd1);
    check("scan served dn3", 32'(bus.servedButton), 32'h0010);
    check("scan floor3", 32'(bus.currentFloor), 32'd3);
    check("scan door3", 32'(bus.doorOpen), 32'd1);
    check("scan dir3", 32'(bus.direction), 32'h1);
    wait_door(1'b0, ok);
    check("scan door close", 32'(ok), 32'd1);
    check("scan idle dir", 32'(bus.direction), 32'd0);

    // Both hall calls at an idle floor are served by one door cycle.
    bus.carButton = 7'h08;
    cycle();
    bus.carButton = '0;
    wait_door(1'b1, ok);
    check("both door4 open", 32'(ok), 32'd1);
    wait_door(1'b0, ok);
    check("both door4 close", 32'(ok), 32'd1);
    check("both floor4", 32'(bus.currentFloor), 32'd4);
    bus.floorButton = 14'h00C0;
    cycle();
    check("both served", 32'(bus.servedButton), 32'h00C0);
    check("both door", 32'(bus.doorOpen), 32'd1);
    check("both dir", 32'(bus.direction), 32'd0);
    seen_served = '0;
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      cycle();
      seen_served = seen_served | bus.servedButton;
      if (bus.doorOpen === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("both door close", 32'(ok), 32'd1);
    check("both extra served", 32'(seen_served), 32'd0);
    reentries = 0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (bus.doorOpen === 1'b1) reentries++;
    end
    check("both reentries", 32'(reentries), 32'd0);
    check("both idle dir", 32'(bus.direction), 32'd0);
    check("both idle floor", 32'(bus.currentFloor), 32'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
Per-car motion and door sequencer for the 2-car, 7-floor elevator system. It consumes the hall-call word assigned to this car by the floor-button assigner, plus this car's cabin buttons. It runs a SCAN (collective) schedule and drives the car's currentFloor/direction back into the assigner. It reports served hall calls so the assigner can drop them.

Parameters:
FLOOR_TICKS, 16, clock cycles to travel one floor (>=2)
DOOR_TICKS, 32, clock cycles door stays open after last (re)start (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
floorButton  in  14  hall calls assigned to this car; floor f uses bits [2f-1:2f-2], {UP,DOWN}
carButton  in  7  cabin buttons, bit f-1 = floor f; level or pulse, latched internally
doorHoldButton  in  1  restarts door timer while door open
currentFloor  out  3  car floor, 1..7
direction  out  2  STOP=00, UP=10, DOWN=01 (UPDOWN=11 never driven)
doorOpen  out  1  door open indicator
servedButton  out  14  one-cycle pulse per hall-call bit served, same bit layout as floorButton
carCallPending  out  7  latched cabin calls

Behaviour:
- Reset values (async, immediate, any state): state IDLE, currentFloor=3'b001, direction=STOP, doorOpen=0, servedButton=0, carCallPending=0, counters=0.
- Masking: floor1 DOWN bit and floor7 UP bit are ignored. carButton bit for the current floor while doorOpen is not latched; it is a no-op.
- Live request terms, combinational from floorButton|carCallPending: reqAbove, reqBelow, reqHereUp, reqHereDown, carHere.
- States: IDLE, MOVE, CHECK, DOOR.
- IDLE, direction=STOP:
  - If carHere|reqHereUp|reqHereDown: go to DOOR. Serve both hall bits at the floor and clear the cabin call.
  - Else if reqAbove: go to MOVE with direction UP.
  - Else if reqBelow: go to MOVE with direction DOWN.
  - reqAbove wins ties.
- MOVE: counter increments each cycle. On the cycle counter==FLOOR_TICKS-1, the next edge steps currentFloor by ±1, clears the counter, and enters CHECK. currentFloor never leaves 1..7: at floor 7 with UP (or floor 1 with DOWN), CHECK always stops or reverses.
- CHECK (1 cycle): stop (go to DOOR) if any of:
  - carHere;
  - hall bit in the travel direction at this floor;
  - opposite hall bit at this floor and no request further ahead.
  Otherwise return to MOVE.
  - Serve the travel-direction bit, or the opposite bit if the car stops for it; in that case direction flips.
- DOOR: doorOpen=1. servedButton pulses exactly in the first DOOR cycle. The cabin call at the floor is cleared.
  - Timer restarts on doorHoldButton, or on a new call at this floor in the current direction; that call is served with a new pulse the next cycle.
  - At expiry, in priority order:
    - requests ahead: MOVE, same direction;
    - opposite hall call here: stay in DOOR, flip direction, pulse that bit, restart timer;
    - requests behind: MOVE, direction reversed;
    - otherwise: IDLE, direction STOP.
  - doorOpen drops on the MOVE/IDLE transition edge.
- doorOpen=1 never coincides with a currentFloor change.
- A floorButton bit withdrawn mid-trip is re-evaluated live; the car does not stop for withdrawn calls.

Decomposition:
- Shared package elevator_pkg holds:
  - STOP/UP/DOWN/UPDOWN 2-bit codes;
  - FLOOR_W=3, NUM_FLOORS=7, BTN_W=14;
  - the floor-to-bit-pair index function;
  - state enum.
- One combinational sub-module, elevator_request_scan, takes currentFloor, floorButton, carCallPending and produces reqAbove, reqBelow, reqHereUp, reqHereDown, carHere.

Test Plan:
- Assert reset mid-MOVE at floor 4 -> same-cycle currentFloor=1, direction=00, doorOpen=0, servedButton=0.
- FLOOR_TICKS=4, DOOR_TICKS=4, idle at floor 1, carButton[2] pulse at cycle 0:
  - cycle 1: direction=10;
  - cycle 5: currentFloor=2;
  - cycle 10: currentFloor=3;
  - cycle 11: doorOpen=1;
  - cycle 15: doorOpen=0, direction=00;
  - carCallPending=0.
- Car moving UP from floor 1, hall DOWN at floor 3 (bit 4) and hall UP at floor 5 (bit 9):
  - passes floor 3, stops at 5 with servedButton=14'h0200;
  - reverses, stops at 3 with servedButton=14'h0010.
- Door open at floor 2, doorHoldButton held 10 cycles -> doorOpen stays 1 until DOOR_TICKS after release.
- Idle at floor 4, floorButton bits 7 and 6 both set -> single DOOR entry, servedButton=14'h00C0, then IDLE.
- Floor7 UP bit (13) and floor1 DOWN bit (0) set alone -> car stays IDLE, no servedButton pulse.
